dilation_shift_controller: RTL

DILATION_SHIFT_CONTROLLER -- requirements
Module: dilation_shift_controller

---
 rtl/dilation_shift_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dilation_shift_controller.sv
// Per-sample sequencer for a dilated shift-buffer stack: latches a sample, strobes the
// buffers whose dilation is due, then starts each layer in turn. Optional DILATION_SHIFT_CONTROLLER_STALL_CNT_EN adds stall_cycles.
module dilation_shift_controller #(
   parameter int unsigned W          = 16,
   parameter int unsigned NUM_LAYERS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   output logic [W-1:0]          buf_data,
   output logic [NUM_LAYERS-1:0] shift_en,
   output logic                  layer_start,
   output logic [2:0]            layer_sel,
   input  logic                  layer_done,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef DILATION_SHIFT_CONTROLLER_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   localparam int unsigned CNT_W = NUM_LAYERS;
   localparam int unsigned SEL_W = 3;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LAYERS - 1);

   typedef enum logic [2:0] {IDLE, SHIFT, START, WAIT, OUT} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   tick_q, tick_d;
   logic [SEL_W-1:0]   layer_sel_q, layer_sel_d;
   logic [W-1:0]       buf_q, buf_d;
   logic [CNT_W-1:0]   shift_en_q;
   logic               in_ready_q, layer_start_q, out_valid_q;

   // Layer k's buffer advances once every 2^k accepted samples.
   function automatic logic [CNT_W-1:0] shift_mask(input logic [CNT_W-1:0] tick);
      logic [CNT_W-1:0] m;
      m = '0;
      for (int k = 0; k < int'(CNT_W); k++) begin
         m[k] = ((tick & CNT_W'((1 << k) - 1)) == '0);
      end
      return m;
   endfunction

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      layer_sel_d = layer_sel_q;
      buf_d       = buf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               buf_d   = in_data;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            tick_d      = tick_q + CNT_W'(1);
            layer_sel_d = '0;
            state_d     = START;
         end
         START: state_d = WAIT;
         WAIT: begin
            if (layer_done) begin
               if (layer_sel_q == LAST_SEL) begin
                  state_d = OUT;
               end else begin
                  layer_sel_d = layer_sel_q + SEL_W'(1);
                  state_d     = START;
               end
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         tick_q        <= '0;
         layer_sel_q   <= '0;
         buf_q         <= '0;
         shift_en_q    <= '0;
         in_ready_q    <= 1'b1;
         layer_start_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         layer_sel_q   <= layer_sel_d;
         buf_q         <= buf_d;
         shift_en_q    <= (state_d == SHIFT) ? shift_mask(tick_q) : '0;
         in_ready_q    <= (state_d == IDLE);
         layer_start_q <= (state_d == START);
         out_valid_q   <= (state_d == OUT);
      end
   end

   assign in_ready    = in_ready_q;
   assign buf_data    = buf_q;
   assign shift_en    = shift_en_q;
   assign layer_start = layer_start_q;
   assign layer_sel   = layer_sel_q;
   assign out_valid   = out_valid_q;

`ifdef DILATION_SHIFT_CONTROLLER_STALL_CNT_EN
   localparam logic [15:0] STALL_MAX = 16'hFFFF;
   logic [15:0] stall_q;

   // Saturating count of cycles the result waits on downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule
